instruction_server: RTL and testbench

Responder side of the processor's instruction-fetch interface. It holds the instruction memory that answers the processor's `Endereco` with `Instrucao` in the same cycle. It runs the boot/program loader that copies a length-prefixed program image from the simulated HD into that memory. While a load is in progress it stalls the processor through `Ocupado`, which drives the PC `Halt`.

---
 rtl/instruction_server_pkg.sv | 19 +
 rtl/instruction_server_instr_ram.sv | 24 ++
 rtl/instruction_server.sv | 132 +++++++++++++
 tb/tb_instruction_server.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_server_pkg.sv
// Shared definitions for the instruction server: loader FSM states and
// the constants describing the program image layout.
package instruction_server_pkg;

    typedef enum logic [2:0] {
        BOOT,
        HEADER,
        LEN,
        COPY,
        DONE,
        IDLE
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Instructions start one word after the length word of an image.
    localparam int HEADER_OFFSET = 1;

endpackage

// File: rtl/instruction_server_instr_ram.sv
// Instruction memory: synchronous write port for the loader, asynchronous
// read port for the processor fetch path. Contents survive reset.
module instr_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_server.sv
// Instruction-fetch responder: serves fetches from instruction memory and
// loads length-prefixed program images from the HD, stalling the PC meanwhile.
module instruction_server
    import instruction_server_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int HD_ADDR_W = 12,
    parameter int BOOT_BASE = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [31:0]          Endereco,
    output logic [31:0]          Instrucao,
    input  logic                 WriteHD,
    input  logic [31:0]          LoadBase,
    output logic                 HDLer,
    output logic [HD_ADDR_W-1:0] HDEndereco,
    input  logic [31:0]          HDDados,
    output logic                 Ocupado,
    output logic                 Pronto,
    output logic                 Erro
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [HD_ADDR_W-1:0] HDR_OFF   = HD_ADDR_W'(HEADER_OFFSET);
    localparam logic [HD_ADDR_W-1:0] BOOT_ADDR = HD_ADDR_W'(BOOT_BASE);

    state_t              state;
    logic [HD_ADDR_W-1:0] base;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   last_idx;
    logic [31:0]         ram_rd_data;
    logic                ram_wr_en;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{LoadBase[31:HD_ADDR_W], Endereco[31:ADDR_W]};

    // Each HD read address is issued one cycle ahead of the word it fetches,
    // so COPY always points at the word needed for the next write index.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= BOOT;
            base       <= '0;
            idx        <= '0;
            last_idx   <= '0;
            HDLer      <= 1'b0;
            HDEndereco <= '0;
            Ocupado    <= 1'b1;
            Pronto     <= 1'b0;
            Erro       <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    base       <= BOOT_ADDR;
                    HDEndereco <= BOOT_ADDR;
                    HDLer      <= 1'b1;
                    Erro       <= 1'b0;
                    state      <= HEADER;
                end
                HEADER: begin
                    HDEndereco <= base + HDR_OFF;
                    HDLer      <= 1'b1;
                    state      <= LEN;
                end
                LEN: begin
                    idx        <= '0;
                    HDEndereco <= HDEndereco + HD_ADDR_W'(1);
                    HDLer      <= (HDDados > 32'd1);
                    if (HDDados > 32'(DEPTH)) begin
                        last_idx <= '1;
                        Erro     <= 1'b1;
                    end else begin
                        last_idx <= ADDR_W'(HDDados - 32'd1);
                    end
                    if (HDDados == 32'd0) begin
                        HDLer  <= 1'b0;
                        Pronto <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state  <= COPY;
                    end
                end
                COPY: begin
                    if (idx == last_idx) begin
                        HDLer  <= 1'b0;
                        Pronto <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx        <= idx + ADDR_W'(1);
                        HDEndereco <= HDEndereco + HD_ADDR_W'(1);
                        HDLer      <= ((idx + ADDR_W'(1)) != last_idx);
                    end
                end
                DONE: begin
                    Pronto  <= 1'b0;
                    Ocupado <= 1'b0;
                    state   <= IDLE;
                end
                IDLE: begin
                    if (WriteHD) begin
                        base       <= LoadBase[HD_ADDR_W-1:0];
                        HDEndereco <= LoadBase[HD_ADDR_W-1:0];
                        HDLer      <= 1'b1;
                        Ocupado    <= 1'b1;
                        Erro       <= 1'b0;
                        state      <= HEADER;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign ram_wr_en = (state == COPY);

    instr_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (Clock),
        .wr_en   (ram_wr_en),
        .wr_addr (idx),
        .wr_data (HDDados),
        .rd_addr (Endereco[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // The processor sees NOPs until the image is completely in place.
    assign Instrucao = Ocupado ? NOP_WORD : ram_rd_data;

endmodule

// File: tb/tb_instruction_server.sv
// Self-checking bench for instruction_server: an HD model answers reads one
// cycle late; loads are timed against edge counts and checked through fetches.
module tb_instruction_server;

    localparam int ADDR_W    = 10;
    localparam int HD_ADDR_W = 12;
    localparam int DEPTH     = 1024;

    localparam logic [31:0] WA = 32'hA000_000A;
    localparam logic [31:0] WB = 32'hB000_000B;
    localparam logic [31:0] WC = 32'hC000_000C;
    localparam logic [31:0] P0 = 32'h1111_0001;
    localparam logic [31:0] P1 = 32'h1111_0002;

    logic                 Clock;
    logic                 Reset;
    logic [31:0]          Endereco;
    logic [31:0]          Instrucao;
    logic                 WriteHD;
    logic [31:0]          LoadBase;
    logic                 HDLer;
    logic [HD_ADDR_W-1:0] HDEndereco;
    logic [31:0]          HDDados;
    logic                 Ocupado;
    logic                 Pronto;
    logic                 Erro;

    typedef struct {
        int          phase;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } fetch_vec_t;

    fetch_vec_t           vecs[$];
    logic [31:0]          hd [4096];
    logic [HD_ADDR_W-1:0] rd_log[$];
    int                   cyc = 0;
    int                   total = 0;
    int                   passed = 0;

    instruction_server #(
        .ADDR_W    (ADDR_W),
        .HD_ADDR_W (HD_ADDR_W),
        .BOOT_BASE (0)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Endereco   (Endereco),
        .Instrucao  (Instrucao),
        .WriteHD    (WriteHD),
        .LoadBase   (LoadBase),
        .HDLer      (HDLer),
        .HDEndereco (HDEndereco),
        .HDDados    (HDDados),
        .Ocupado    (Ocupado),
        .Pronto     (Pronto),
        .Erro       (Erro)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // HD model: data for a strobed address appears in the following cycle.
    always @(posedge Clock) begin
        if (HDLer) begin
            HDDados <= hd[HDEndereco];
            rd_log.push_back(HDEndereco);
        end
    end

    function automatic logic [31:0] pat(input int i);
        return 32'h5EED_0000 | 32'(i);
    endfunction

    function automatic fetch_vec_t fv(input int ph, input logic [31:0] a,
                                      input logic [31:0] e, input string n);
        fetch_vec_t v;
        v.phase = ph;
        v.addr  = a;
        v.exp   = e;
        v.name  = n;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply_stimulus(input int phase);
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                @(negedge Clock);
                Endereco = vecs[i].addr;
                #1;
                check_output(vecs[i].name, Instrucao, vecs[i].exp);
            end
        end
    endtask

    task automatic wait_pronto(input int limit, output int edge_at);
        int nop_bad;
        nop_bad = 0;
        edge_at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clock);
            if (Instrucao !== 32'h0 || Ocupado !== 1'b1) nop_bad++;
            if (Pronto === 1'b1) begin
                edge_at = cyc;
                break;
            end
        end
        if (edge_at < 0) begin
            total++;
            $display("[TB] FAIL pronto_timeout: got no Pronto expected Pronto within %0d cycles", limit);
        end
        check_output("nop_while_busy", 32'(nop_bad), 32'd0);
    endtask

    task automatic start_load(input logic [31:0] base, output int e0);
        @(negedge Clock);
        rd_log.delete();
        WriteHD  = 1'b1;
        LoadBase = base;
        e0       = cyc + 1;
        @(negedge Clock);
        WriteHD  = 1'b0;
        check_output("header_rd", 32'(HDLer), 32'd1);
        check_output("header_addr", 32'(HDEndereco), 32'(base[HD_ADDR_W-1:0]));
        check_output("header_erro", 32'(Erro), 32'd0);
    endtask

    task automatic finish_load(input string tag, input int e0, input int n_eff);
        int pe;
        wait_pronto(DEPTH + 20, pe);
        check_output({tag, "_latency"}, 32'(pe - e0), 32'(n_eff + 2));
        @(negedge Clock);
        check_output({tag, "_ocupado"}, 32'(Ocupado), 32'd0);
        check_output({tag, "_pronto"}, 32'(Pronto), 32'd0);
    endtask

    initial begin
        int e0;
        int wrap_exp [4];

        for (int i = 0; i < 4096; i++) hd[i] = pat(i);
        hd[0]    = 32'd3;
        hd[1]    = WA;
        hd[2]    = WB;
        hd[3]    = WC;
        hd[50]   = 32'd0;
        hd[100]  = 32'd2;
        hd[101]  = P0;
        hd[102]  = P1;
        hd[200]  = 32'(DEPTH + 5);
        hd[300]  = 32'd4;
        hd[4094] = 32'd3;
        wrap_exp = '{4094, 4095, 0, 1};

        vecs.push_back(fv(1, 32'd0, WA, "boot_m0"));
        vecs.push_back(fv(1, 32'd1, WB, "boot_m1"));
        vecs.push_back(fv(1, 32'd2, WC, "boot_m2"));
        vecs.push_back(fv(1, 32'h0000_0400, WA, "boot_upper_ignored"));
        vecs.push_back(fv(2, 32'd0, P0, "prog_m0"));
        vecs.push_back(fv(2, 32'd1, P1, "prog_m1"));
        vecs.push_back(fv(2, 32'd2, WC, "prog_m2_kept"));
        vecs.push_back(fv(3, 32'd0, P0, "n0_m0"));
        vecs.push_back(fv(3, 32'hFFFF_FC01, P1, "n0_m1"));
        vecs.push_back(fv(3, 32'd2, WC, "n0_m2"));
        vecs.push_back(fv(4, 32'd0, pat(201), "trunc_m0"));
        vecs.push_back(fv(4, 32'd500, pat(701), "trunc_m500"));
        vecs.push_back(fv(4, 32'd1023, pat(1224), "trunc_m1023"));
        vecs.push_back(fv(4, 32'h8000_0003, pat(204), "trunc_m3_upper"));
        vecs.push_back(fv(5, 32'd0, P0, "reload_m0"));
        vecs.push_back(fv(5, 32'd1, P1, "reload_m1"));
        vecs.push_back(fv(5, 32'd2, pat(203), "reload_m2_kept"));
        vecs.push_back(fv(6, 32'd0, pat(301), "pulse_m0"));
        vecs.push_back(fv(6, 32'd1, pat(302), "pulse_m1"));
        vecs.push_back(fv(6, 32'd2, pat(303), "pulse_m2"));
        vecs.push_back(fv(6, 32'd3, pat(304), "pulse_m3"));
        vecs.push_back(fv(6, 32'd4, pat(205), "pulse_m4_kept"));
        vecs.push_back(fv(7, 32'd0, WA, "rst_m0"));
        vecs.push_back(fv(7, 32'd1, WB, "rst_m1"));
        vecs.push_back(fv(7, 32'd2, WC, "rst_m2"));
        vecs.push_back(fv(7, 32'd3, pat(204), "rst_m3_kept"));
        vecs.push_back(fv(7, 32'd600, pat(801), "rst_m600_kept"));
        vecs.push_back(fv(8, 32'd0, pat(4095), "wrap_m0"));
        vecs.push_back(fv(8, 32'd1, 32'd3, "wrap_m1"));
        vecs.push_back(fv(8, 32'd2, WA, "wrap_m2"));
        vecs.push_back(fv(8, 32'd3, pat(204), "wrap_m3_kept"));

        Reset    = 1'b0;
        WriteHD  = 1'b0;
        LoadBase = 32'd0;
        Endereco = 32'd0;
        repeat (3) @(negedge Clock);
        check_output("rst_ocupado", 32'(Ocupado), 32'd1);
        check_output("rst_pronto", 32'(Pronto), 32'd0);
        check_output("rst_erro", 32'(Erro), 32'd0);
        check_output("rst_hdler", 32'(HDLer), 32'd0);
        check_output("rst_hdaddr", 32'(HDEndereco), 32'd0);
        check_output("rst_instr", Instrucao, 32'd0);

        // Boot image: first edge after release is E0.
        Reset = 1'b1;
        e0    = cyc + 1;
        finish_load("boot", e0, 3);
        check_output("boot_erro", 32'(Erro), 32'd0);
        apply_stimulus(1);

        start_load(32'd100, e0);
        finish_load("prog", e0, 2);
        check_output("prog_reads", 32'(rd_log.size()), 32'd3);
        apply_stimulus(2);

        start_load(32'd50, e0);
        finish_load("n0", e0, 0);
        check_output("n0_reads", 32'(rd_log.size()), 32'd2);
        check_output("n0_erro", 32'(Erro), 32'd0);
        apply_stimulus(3);

        start_load(32'd200, e0);
        finish_load("trunc", e0, DEPTH);
        check_output("trunc_reads", 32'(rd_log.size()), 32'(DEPTH + 1));
        check_output("trunc_erro", 32'(Erro), 32'd1);
        apply_stimulus(4);

        start_load(32'd100, e0);
        finish_load("reload", e0, 2);
        apply_stimulus(5);

        // A request raised mid-COPY must not disturb the running load.
        start_load(32'd300, e0);
        @(negedge Clock);
        @(negedge Clock);
        WriteHD  = 1'b1;
        LoadBase = 32'd100;
        @(negedge Clock);
        WriteHD  = 1'b0;
        finish_load("pulse", e0, 4);
        apply_stimulus(6);

        // Reset in the middle of a long COPY, then the boot image reloads.
        start_load(32'd200, e0);
        repeat (10) @(negedge Clock);
        Reset = 1'b0;
        #1;
        check_output("midrst_ocupado", 32'(Ocupado), 32'd1);
        check_output("midrst_instr", Instrucao, 32'd0);
        check_output("midrst_hdler", 32'(HDLer), 32'd0);
        check_output("midrst_erro", 32'(Erro), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        e0    = cyc + 1;
        finish_load("reboot", e0, 3);
        apply_stimulus(7);

        start_load(32'd4094, e0);
        finish_load("wrap", e0, 3);
        check_output("wrap_reads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("wrap_rd%0d", i),
                         (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF,
                         32'(wrap_exp[i]));
        end
        apply_stimulus(8);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
